// File: rtl/uart_pkg.sv
// Shared types, default constants and the majority-vote helper for the UART receive path.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser on the serial line plus a tick-qualified falling-edge detector.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_rx_prev;

   // Idle-high reset so a quiet line never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta    <= 1'b1;
         r_sync    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_meta <= rx;
         r_sync <= r_meta;
         if (tick) r_rx_prev <= r_sync;
      end
   end

   assign rx_s = r_sync;
   assign fall = tick & r_rx_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front-end: start validation, mid-bit 3-sample vote, stop/parity check.
// Optional parity bit is built when UART_RX_PARITY_EN is defined.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic rx,
   output logic sample,
   output logic rx_bit,
   output logic frame_start,
   output logic frame_done,
   output logic frame_err,
   output logic parity_err,
   output logic busy
);

   localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam int unsigned MID   = OVERSAMPLE / 2;
   localparam logic [OS_W-1:0]  OS_LO    = OS_W'(MID - 1);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(MID);
   localparam logic [OS_W-1:0]  OS_HI    = OS_W'(MID + 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   rx_state_t        r_state, w_state_nxt;
   logic [OS_W-1:0]  r_os_cnt, w_os_nxt;
   logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
   logic             r_v0, w_v0_nxt;
   logic             r_v1, w_v1_nxt;
   logic             r_sample, w_sample_nxt;
   logic             r_rx_bit, w_rx_bit_nxt;
   logic             r_start, w_start_nxt;
   logic             r_done, w_done_nxt;
   logic             r_ferr, w_ferr_nxt;
   logic             r_perr, w_perr_nxt;
   logic             r_busy;
`ifdef UART_RX_PARITY_EN
   logic             r_par, w_par_nxt;
   logic             r_pflag, w_pflag_nxt;
`endif

   logic w_rx_s;
   logic w_fall;
   logic w_vote;
   logic w_decide;
   logic w_bit_end;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .rx    (rx),
      .rx_s  (w_rx_s),
      .fall  (w_fall)
   );

   // Third vote sample is the live synchronised value on the decision tick.
   assign w_vote    = maj3(r_v0, r_v1, w_rx_s);
   assign w_decide  = tick && (r_os_cnt == OS_HI);
   assign w_bit_end = tick && (r_os_cnt == OS_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_os_cnt  <= '0;
         r_bit_cnt <= '0;
         r_v0      <= 1'b1;
         r_v1      <= 1'b1;
         r_sample  <= 1'b0;
         r_rx_bit  <= 1'b0;
         r_start   <= 1'b0;
         r_done    <= 1'b0;
         r_ferr    <= 1'b0;
         r_perr    <= 1'b0;
         r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par     <= 1'b0;
         r_pflag   <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_os_cnt  <= w_os_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_v0      <= w_v0_nxt;
         r_v1      <= w_v1_nxt;
         r_sample  <= w_sample_nxt;
         r_rx_bit  <= w_rx_bit_nxt;
         r_start   <= w_start_nxt;
         r_done    <= w_done_nxt;
         r_ferr    <= w_ferr_nxt;
         r_perr    <= w_perr_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
`ifdef UART_RX_PARITY_EN
         r_par     <= w_par_nxt;
         r_pflag   <= w_pflag_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_os_nxt     = r_os_cnt;
      w_bit_nxt    = r_bit_cnt;
      w_v0_nxt     = r_v0;
      w_v1_nxt     = r_v1;
      w_sample_nxt = 1'b0;
      w_rx_bit_nxt = 1'b0;
      w_start_nxt  = 1'b0;
      w_done_nxt   = 1'b0;
      w_ferr_nxt   = 1'b0;
      w_perr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt    = r_par;
      w_pflag_nxt  = r_pflag;
`endif

      if (tick && (r_state != S_IDLE)) begin
         w_os_nxt = r_os_cnt + OS_W'(1);
         if (r_os_cnt == OS_LO)  w_v0_nxt = w_rx_s;
         if (r_os_cnt == OS_MID) w_v1_nxt = w_rx_s;
      end

      unique case (r_state)
         S_IDLE: begin
            // Edge tick counts as os 0 of the start bit.
            if (w_fall) begin
               w_state_nxt = S_START;
               w_os_nxt    = OS_W'(1);
            end
         end
         S_START: begin
            if (w_decide) begin
               if (w_vote) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_start_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  w_par_nxt   = 1'b0;
                  w_pflag_nxt = 1'b0;
`endif
               end
            end else if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_os_nxt    = '0;
               w_bit_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_decide) begin
               w_sample_nxt = 1'b1;
               w_rx_bit_nxt = w_vote;
`ifdef UART_RX_PARITY_EN
               w_par_nxt    = r_par ^ w_vote;
`endif
            end else if (w_bit_end) begin
               w_os_nxt = '0;
               if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_bit_nxt = r_bit_cnt + BIT_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_decide) begin
               w_pflag_nxt = w_vote ^ r_par ^ 1'(PARITY_ODD);
            end else if (w_bit_end) begin
               w_state_nxt = S_STOP;
               w_os_nxt    = '0;
            end
         end
`endif
         S_STOP: begin
            // Leave at the decision so a back-to-back start edge is not missed.
            if (w_decide) begin
               w_done_nxt  = 1'b1;
               w_ferr_nxt  = ~w_vote;
`ifdef UART_RX_PARITY_EN
               w_perr_nxt  = r_pflag;
`endif
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign sample      = r_sample;
   assign rx_bit      = r_rx_bit;
   assign frame_start = r_start;
   assign frame_done  = r_done;
   assign frame_err   = r_ferr;
   assign parity_err  = r_perr;
   assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed scoreboard bench for uart_rx_sampler (OVERSAMPLE=16, DATA_BITS=8, tick every 4 clk).
module tb_uart_rx_sampler;

   localparam int BIT_CLK = 64;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tick = 1'b0;
   logic rx = 1'b1;
   logic sample, rx_bit, frame_start, frame_done, frame_err, parity_err, busy;

   int n_vec = 0;
   int n_err = 0;
   int n_start = 0;
   int n_sample = 0;
   int idx = 0;
   int tcnt = 0;
   logic [7:0] shreg = '0;
   logic       exp_b;
   done_t      exp_d;

   logic  exp_bits[$];
   done_t exp_done[$];

   uart_rx_sampler #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_ODD(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .rx          (rx),
      .sample      (sample),
      .rx_bit      (rx_bit),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tcnt = tcnt + 1;
      tick = ((tcnt % 4) == 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor and shift-stage model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("pulse_excl", 32'($countones({sample, frame_start, frame_done}) <= 1), 32'd1);
         if (!frame_done) check("err_quiet", 32'({frame_err, parity_err}), 32'd0);
         if (frame_start) begin
            n_start++;
            idx   = 0;
            shreg = '0;
         end
         if (sample) begin
            n_sample++;
            check("sample_expected", 32'(exp_bits.size() != 0), 32'd1);
            if (exp_bits.size() != 0) begin
               exp_b = exp_bits.pop_front();
               check("rx_bit", 32'(rx_bit), 32'(exp_b));
            end
            shreg[idx[2:0]] = rx_bit;
            idx++;
         end
         if (frame_done) begin
            check("done_expected", 32'(exp_done.size() != 0), 32'd1);
            if (exp_done.size() != 0) begin
               exp_d = exp_done.pop_front();
               check("frame_err", 32'(frame_err), 32'(exp_d.ferr));
               check("parity_err", 32'(parity_err), 32'(exp_d.perr));
               check("shift_byte", 32'(shreg), 32'(exp_d.data));
            end
         end
      end
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && (exp_done.size() != 0 || exp_bits.size() != 0); i++)
         @(negedge clk);
      check("drain_done", 32'(exp_done.size()), 32'd0);
      check("drain_bits", 32'(exp_bits.size()), 32'd0);
   endtask

   // glitch: data-bit index that gets a one-tick-wide inverted pulse at mid-bit (-1 = none).
   task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch,
                             input logic par_flip);
      int   s0;
      logic perr;
      s0   = n_start;
      perr = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr = par_flip;
`endif
      for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
      exp_done.push_back(done_t'{data, ~stop, perr});
      drive_bit(1'b0);
      check("busy_mid", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch) begin
            rx = data[i];
            repeat (30) @(negedge clk);
            rx = ~data[i];
            repeat (4) @(negedge clk);
            rx = data[i];
            repeat (30) @(negedge clk);
         end else begin
            drive_bit(data[i]);
         end
      end
`ifdef UART_RX_PARITY_EN
      drive_bit((^data) ^ par_flip);
`endif
      drive_bit(stop);
      wait_drain();
      check("start_cnt", 32'(n_start), 32'(s0 + 1));
   endtask

   initial begin
      int s0;
      int sm;

      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_outputs", 32'({sample, rx_bit, frame_start, frame_done, frame_err, parity_err, busy}), 32'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // Normal frame
      send_frame(8'hA5, 1'b1, -1, 1'b0);
      repeat (20) @(negedge clk);

      // False start: 3-tick glitch
      s0 = n_start;
      sm = n_sample;
      rx = 1'b0;
      repeat (12) @(negedge clk);
      rx = 1'b1;
      repeat (52) @(negedge clk);
      check("false_busy", 32'(busy), 32'd0);
      check("false_start", 32'(n_start), 32'(s0));
      check("false_sample", 32'(n_sample), 32'(sm));
      repeat (64) @(negedge clk);

      // Mid-bit noise on bit 3
      send_frame(8'h00, 1'b1, 3, 1'b0);

      // Back-to-back frame
      send_frame(8'hC3, 1'b1, -1, 1'b0);
      repeat (64) @(negedge clk);

      // Framing error, then break for 3 bit periods
      send_frame(8'h5A, 1'b0, -1, 1'b0);
      s0 = n_start;
      rx = 1'b0;
      repeat (3 * BIT_CLK) @(negedge clk);
      check("break_no_start", 32'(n_start), 32'(s0));
      check("break_busy", 32'(busy), 32'd0);
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
      send_frame(8'h3C, 1'b1, -1, 1'b0);
      repeat (64) @(negedge clk);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, -1, 1'b0);
      repeat (64) @(negedge clk);
      send_frame(8'h07, 1'b1, -1, 1'b1);
      repeat (64) @(negedge clk);
`endif

      // Reset after 4 sample pulses
      sm = n_sample;
      exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b0);
      exp_bits.push_back(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      check("rst_samples", 32'(n_sample), 32'(sm + 4));
      rx    = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", 32'({sample, rx_bit, frame_start, frame_done, frame_err, parity_err, busy}), 32'd0);
      rst_n = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      check("rst_idle_busy", 32'(busy), 32'd0);
      send_frame(8'h81, 1'b1, -1, 1'b0);
      repeat (64) @(negedge clk);
      check("final_queue", 32'(exp_bits.size() + exp_done.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front-end of the UART receiver, directly upstream of the RX shift stage. It synchronises the asynchronous `rx` line and detects and validates the start bit. For each data bit it takes a 3-sample majority vote at mid-bit and emits a one-cycle `sample` pulse with the voted `rx_bit`; the shift stage assembles the byte from these pulses. It also checks the stop bit (and optionally parity) and reports frame completion and errors.

## Interface
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥ 8.
- `DATA_BITS`, 8: data bits per frame; range 5..9.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; used only with the parity feature.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick`  in  1  oversample enable, one-cycle pulse at OVERSAMPLE × baud.
- `rx`  in  1  asynchronous serial line, idle high.
- `sample`  out  1  one-cycle pulse per data bit; `rx_bit` is valid in the same cycle.
- `rx_bit`  out  1  voted data-bit value, LSB first.
- `frame_start`  out  1  one-cycle pulse when a start bit is validated; downstream clears its bit index.
- `frame_done`  out  1  one-cycle pulse after the stop-bit decision.
- `frame_err`  out  1  valid with `frame_done`; stop bit voted 0.
- `parity_err`  out  1  valid with `frame_done`; parity mismatch.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Synchroniser:** 2-flop on `rx`; flops reset to 1. `rx_prev` holds the synchronised value at the last tick and resets to 1.
- **FSM:** states IDLE, START, DATA, PARITY, STOP.
- **Bit counters:** `os_cnt` runs 0..OVERSAMPLE-1 within a bit. `bit_cnt` runs 0..DATA_BITS-1.
- **Vote ticks:** let M = OVERSAMPLE/2. Vote samples are taken on ticks where `os_cnt` = M-1, M and M+1. The decision is the majority of the three and is taken on the M+1 tick.
- **IDLE:**
  - Detection is edge-based, not level-based: on a tick where the synchronised rx is 0 and `rx_prev` is 1, go to START with `os_cnt`←1.
  - A line held low (break) never retriggers.
- **START:**
  - Decision 1 (false start): return to IDLE; no `frame_start`.
  - Decision 0: pulse `frame_start`.
  - On the tick where `os_cnt` = OVERSAMPLE-1, go to DATA with `os_cnt`←0 and `bit_cnt`←0.
- **DATA:**
  - Each decision pulses `sample` with `rx_bit` = vote and updates the running parity XOR.
  - At the end of the bit period: if `bit_cnt` = DATA_BITS-1, go to PARITY (feature enabled) or STOP; otherwise increment `bit_cnt`.
- **PARITY:** the decision compares the vote against the expected parity and latches a mismatch flag. At the end of the bit, go to STOP.
- **STOP:**
  - The decision pulses `frame_done`, with `frame_err` = ~vote and `parity_err` = the latched flag.
  - Go to IDLE at the decision; do not wait for the end of the bit. This allows back-to-back frames.
- **No ticks:** with no `tick`, all counters and state hold.
- **Reset values:** all outputs 0 and state IDLE. Reset mid-frame aborts at the next edge with no pulses.

## Timing
- `rx` to synchronised value: 2 clk.
- `sample`, `frame_start` and `frame_done` are registered and assert the clk after the M+1 tick; each is exactly one cycle wide.
- `frame_err` and `parity_err` are 0 whenever `frame_done` is 0.
- At most one of `sample`, `frame_start` or `frame_done` is asserted per cycle.
- Start-edge-to-first-`sample` is 1.5 bit periods, ±1 tick of edge-detection uncertainty.
- `tick` arriving in the same cycle as `rst_n` low is ignored.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and parity XOR are built; one parity bit follows the data bits.
  - `parity_err` reports a mismatch against the `PARITY_ODD` sense.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - The `parity_err` port still exists and is tied to 0.

## Structure
- **Shared package `uart_pkg`:**
  - the FSM state enum;
  - default OVERSAMPLE and DATA_BITS constants;
  - a `maj3` function.
- **Sub-module `uart_rx_sync`:** the 2-flop synchroniser plus tick-qualified falling-edge detector. Outputs: `rx_s`, `fall`.
- The FSM, counters and vote logic live in `uart_rx_sampler`.

## Test plan
Common setup: OVERSAMPLE=16, DATA_BITS=8, `tick` every 4 clk.
- **Normal frame:** send 0xA5 8N1. Require:
  - one `frame_start`;
  - 8 `sample` pulses with `rx_bit` = 1,0,1,0,0,1,0,1;
  - `frame_done` with `frame_err`=0;
  - the shift stage yields 0xA5.
- **False start:** glitch `rx` low for 3 ticks. Require no `frame_start`, no `sample`, `busy` back to 0 within 1 bit period.
- **Mid-bit noise:** send 0x00 with `rx` flipped high only on the `os_cnt`=M tick of bit 3. Require all `rx_bit`=0.
- **Framing error and break:**
  - Stop bit held low. Require `frame_done` with `frame_err`=1.
  - Line kept low for 3 bit periods. Require no second `frame_start`.
  - Release high, then send 0x3C. Require it is received correctly.
- **Parity (macro defined, `PARITY_ODD`=0):**
  - 0x07 with parity bit 1: `parity_err`=0.
  - Same data with parity bit 0: `parity_err`=1 with `frame_done`.
- **Reset mid-frame:** assert `rst_n`=0 for 1 clk after 4 `sample` pulses. Require:
  - all outputs 0 and `busy`=0 the next cycle;
  - the following 0x81 frame is received intact.
